// File: rtl/idma_sched_pkg.sv
// Shared types for the iDMA multi-channel scheduler: channel tag and issue-slot state.
package idma_sched_pkg;

    // Sized for the largest supported channel count so one tag type serves every instance.
    localparam int unsigned MaxChan = 16;

    typedef logic [$clog2(MaxChan)-1:0] chan_id_t;

    typedef enum logic {
        ISSUE_EMPTY,
        ISSUE_FULL
    } issue_state_e;

endpackage

// File: rtl/idma_chan_sched_if.sv
// Bundle of frontend-facing and backend-facing signals around the channel scheduler.
interface idma_chan_sched_if #(
    parameter int unsigned NumChan    = 4,
    parameter type         idma_req_t = logic
);
    logic [NumChan-1:0] chan_en;
    idma_req_t          chan_req [NumChan];
    logic [NumChan-1:0] chan_valid;
    logic [NumChan-1:0] chan_ready;
    idma_req_t          be_req;
    logic               be_valid;
    logic               be_ready;
    logic               be_done;
    logic [NumChan-1:0] chan_done;
    logic [NumChan-1:0] chan_busy;
    logic [NumChan-1:0] irq;
    logic [NumChan-1:0] irq_clr;
    logic               err;

    // master: frontends plus backend; slave: the scheduler itself.
    modport master (
        output chan_en, chan_req, chan_valid, be_ready, be_done, irq_clr,
        input  chan_ready, be_req, be_valid, chan_done, chan_busy, irq, err
    );

    modport slave (
        input  chan_en, chan_req, chan_valid, be_ready, be_done, irq_clr,
        output chan_ready, be_req, be_valid, chan_done, chan_busy, irq, err
    );
endinterface

// File: rtl/idma_chan_sched_tag_fifo.sv
// In-order FIFO of issuing-channel tags; pop is applied before push so a full FIFO can swap an entry.
module idma_chan_sched_tag_fifo
    import idma_sched_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push,
    input  chan_id_t data_in,
    input  logic     pop,
    output chan_id_t data_out,
    output logic     empty,
    output logic     full
);
    localparam int unsigned AddrWidth = $clog2(Depth);
    localparam logic [AddrWidth:0] FullCount = Depth[AddrWidth:0];

    chan_id_t             mem [Depth];
    logic [AddrWidth-1:0] rd_ptr_q, wr_ptr_q;
    logic [AddrWidth:0]   usage_q;
    logic                 do_push, do_pop;

    assign empty    = (usage_q == '0);
    assign full     = (usage_q == FullCount);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr_q];

    // NOTE: storage has no reset; usage_q alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= data_in;
    end

    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      usage_q <= usage_q + 1'b1;
            else if (do_pop && !do_push) usage_q <= usage_q - 1'b1;
        end
    end

endmodule

// File: rtl/idma_chan_sched.sv
// Round-robin scheduler sharing one iDMA backend between NumChan frontends, with
// a registered issue slot, outstanding-transfer credit and per-channel completion routing.
module idma_chan_sched
    import idma_sched_pkg::*;
#(
    parameter int unsigned NumChan        = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         idma_req_t     = logic
) (
    input logic              clk_i,
    input logic              rst_i,
    idma_chan_sched_if.slave bus
);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    issue_state_e        state_q;
    idma_req_t           be_req_q, gnt_req;
    chan_id_t            rr_ptr_q, gnt_idx, pop_tag;
    logic [NumChan-1:0]  cand, ready, done_set, done_q, irq_q, busy_q;
    logic                gnt_found, can_load, grant, pop, err_q;
    logic                fifo_full, fifo_empty;
    logic [CntWidth-1:0] cnt_q [NumChan];
    logic [CntWidth-1:0] cnt_d [NumChan];

    assign cand     = bus.chan_valid & bus.chan_en;
    assign can_load = (state_q == ISSUE_EMPTY) || bus.be_ready;
    assign pop      = bus.be_done && !fifo_empty;
    // A same-cycle completion frees a credit, so a full FIFO can still accept a grant.
    assign grant    = gnt_found && can_load && (!fifo_full || bus.be_done) && !rst_i;

    // NOTE: combinational blocks use = and assign every output a default first, so no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NumChan; k++) begin
            if (!gnt_found && cand[k] && (chan_id_t'(k) >= rr_ptr_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = chan_id_t'(k);
            end
        end
        for (int k = 0; k < NumChan; k++) begin
            if (!gnt_found && cand[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = chan_id_t'(k);
            end
        end
    end

    always_comb begin
        gnt_req = bus.chan_req[0];
        for (int k = 0; k < NumChan; k++) begin
            ready[k]    = grant && (gnt_idx == chan_id_t'(k));
            done_set[k] = pop && (pop_tag == chan_id_t'(k));
            if (gnt_idx == chan_id_t'(k)) gnt_req = bus.chan_req[k];
            cnt_d[k] = cnt_q[k];
            if (ready[k])    cnt_d[k] = cnt_d[k] + CntWidth'(1);
            if (done_set[k]) cnt_d[k] = cnt_d[k] - CntWidth'(1);
        end
    end

    // Issue slot: once FULL, the request is held unchanged until the backend takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ISSUE_EMPTY;
            be_req_q <= '0;
        end else if (grant) begin
            state_q  <= ISSUE_FULL;
            be_req_q <= gnt_req;
        end else if ((state_q == ISSUE_FULL) && bus.be_ready) begin
            state_q  <= ISSUE_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            done_q   <= '0;
            irq_q    <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < NumChan; k++) cnt_q[k] <= '0;
        end else begin
            if (grant) begin
                rr_ptr_q <= (gnt_idx == chan_id_t'(NumChan - 1)) ? '0 : gnt_idx + chan_id_t'(1);
            end
            done_q <= done_set;
            irq_q  <= (irq_q & ~bus.irq_clr) | done_set;
            if (bus.be_done && fifo_empty) err_q <= 1'b1;
            for (int k = 0; k < NumChan; k++) begin
                cnt_q[k]  <= cnt_d[k];
                busy_q[k] <= (cnt_d[k] != '0);
            end
        end
    end

    idma_chan_sched_tag_fifo #(
        .Depth (MaxOutstanding)
    ) i_tag_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (grant),
        .data_in  (gnt_idx),
        .pop      (bus.be_done),
        .data_out (pop_tag),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.chan_ready = ready;
    assign bus.be_req     = be_req_q;
    assign bus.be_valid   = (state_q == ISSUE_FULL);
    assign bus.chan_done  = done_q;
    assign bus.chan_busy  = busy_q;
    assign bus.irq        = irq_q;
    assign bus.err        = err_q;

endmodule
